// File: rtl/dpll_nco_core.sv
// dpll_nco_core: all-digital PLL core. A phase-accumulator NCO is steered by a
// sampled phase detector and a PI loop filter. Includes lock detection and
// holdover when the reference is lost.
//
// Ports:
//   clk        system clock; all state updates on the rising edge
//   rst        asynchronous active-high reset
//   ena        clock enable; when low, every register holds its value
//   ref_in     asynchronous reference clock (synchronised internally)
//   mode       00 open-loop, 01 closed-loop PI, 10 hold, 11 same as 00
//   fcw_nom    nominal frequency control word
//   nco_out    registered accumulator MSB
//   fcw_out    effective FCW applied to the accumulator
//   phase_err  signed phase error sampled at the last reference edge
//   lock       lock indicator
//   ref_lost   reference timeout flag
module dpll_nco_core #(
   parameter int unsigned ACC_W       = 16,
   parameter int unsigned FCW_W       = 12,
   parameter int unsigned ERR_W       = 8,
   parameter int unsigned KP_SHIFT    = 2,
   parameter int unsigned KI_SHIFT    = 5,
   parameter int unsigned LOCK_TOL    = 4,
   parameter int unsigned LOCK_CNT    = 16,
   parameter int unsigned REF_TIMEOUT = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             ref_in,
   input  logic [1:0]       mode,
   input  logic [FCW_W-1:0] fcw_nom,
   output logic             nco_out,
   output logic [FCW_W-1:0] fcw_out,
   output logic [ERR_W-1:0] phase_err,
   output logic             lock,
   output logic             ref_lost
);

   localparam int unsigned I_W   = FCW_W + 2;
   localparam int unsigned S_W   = FCW_W + 3;
   localparam int unsigned CNT_W = $clog2(LOCK_CNT + 1);
   localparam int unsigned GAP_W = $clog2(REF_TIMEOUT + 1);

   localparam logic [1:0] MODE_PI   = 2'b01;
   localparam logic [1:0] MODE_HOLD = 2'b10;

   localparam logic signed [S_W-1:0] I_MAX   = S_W'((1 << (FCW_W + 1)) - 1);
   localparam logic signed [S_W-1:0] I_MIN   = -I_MAX;
   localparam logic signed [S_W-1:0] FCW_MIN = S_W'(1);
   localparam logic signed [S_W-1:0] FCW_MAX = S_W'((1 << FCW_W) - 1);

   logic [2:0]              ref_sync;
   logic                    ref_edge;
   logic [ACC_W-1:0]        acc;
   logic signed [I_W-1:0]   integ;
   logic signed [I_W-1:0]   integ_nxt;
   logic [CNT_W-1:0]        lock_cnt;
   logic [CNT_W-1:0]        lock_cnt_nxt;
   logic                    lock_nxt;
   logic [GAP_W-1:0]        gap_cnt;
   logic [GAP_W-1:0]        gap_nxt;
   logic                    ref_lost_nxt;
   logic [FCW_W-1:0]        fcw_nxt;

   logic signed [ERR_W-1:0] err;
   logic signed [ERR_W:0]   err_wide;
   logic [ERR_W:0]          err_abs;
   logic                    err_in_tol;
   logic signed [S_W-1:0]   err_kp;
   logic signed [S_W-1:0]   err_ki;
   logic signed [S_W-1:0]   integ_ext;
   logic signed [S_W-1:0]   integ_sum;
   logic signed [S_W-1:0]   integ_sat;
   logic signed [S_W-1:0]   corr;
   logic signed [S_W-1:0]   fcw_nom_ext;
   logic signed [S_W-1:0]   fcw_diff;

   // Two sync stages ([0],[1]) plus one history bit ([2]) for rising-edge detect
   assign ref_edge = ref_sync[1] & ~ref_sync[2];

   // Phase error: top ERR_W accumulator bits; zero when the ref edge hits the wrap
   assign err      = acc[ACC_W-1 -: ERR_W];
   assign err_kp   = S_W'(err) >>> KP_SHIFT;
   assign err_ki   = S_W'(err) >>> KI_SHIFT;

   // One extra bit so the most negative error has a representable magnitude
   assign err_wide   = {err[ERR_W-1], err};
   assign err_abs    = err_wide[ERR_W] ? (-err_wide) : err_wide;
   assign err_in_tol = (err_abs <= (ERR_W+1)'(LOCK_TOL));

   assign integ_ext   = {{(S_W-I_W){integ[I_W-1]}}, integ};
   assign fcw_nom_ext = {{(S_W-FCW_W){1'b0}}, fcw_nom};

   // Loop filter: integrator update and frequency correction for this cycle
   always_comb begin
      integ_nxt = integ;
      corr      = integ_ext;
      integ_sum = integ_ext + err_ki;
      integ_sat = integ_sum;
      if (integ_sum > I_MAX) begin
         integ_sat = I_MAX;
      end else if (integ_sum < I_MIN) begin
         integ_sat = I_MIN;
      end
      case (mode)
         MODE_PI: begin
            // With the reference lost, PI mode degrades to hold
            if (!ref_lost && ref_edge) begin
               integ_nxt = I_W'(integ_sat);
               corr      = err_kp + integ_sat;
            end
         end
         MODE_HOLD: corr = integ_ext;
         default: begin
            integ_nxt = '0;
            corr      = '0;
         end
      endcase
   end

   // Effective FCW, clamped so the NCO never stalls or wraps the word
   always_comb begin
      fcw_diff = fcw_nom_ext - corr;
      if (fcw_diff < FCW_MIN) begin
         fcw_nxt = FCW_W'(FCW_MIN);
      end else if (fcw_diff > FCW_MAX) begin
         fcw_nxt = FCW_W'(FCW_MAX);
      end else begin
         fcw_nxt = FCW_W'(fcw_diff);
      end
   end

   // Lock detector: consecutive in-tolerance edges, only while tracking in PI
   always_comb begin
      lock_cnt_nxt = lock_cnt;
      lock_nxt     = lock;
      if ((mode != MODE_PI) || ref_lost) begin
         lock_cnt_nxt = '0;
         lock_nxt     = 1'b0;
      end else if (ref_edge) begin
         if (err_in_tol) begin
            if (lock_cnt != CNT_W'(LOCK_CNT)) begin
               lock_cnt_nxt = lock_cnt + CNT_W'(1);
            end
            lock_nxt = (lock_cnt_nxt == CNT_W'(LOCK_CNT));
         end else begin
            lock_cnt_nxt = '0;
            lock_nxt     = 1'b0;
         end
      end
   end

   // Reference watchdog; an edge on the timeout cycle takes priority
   always_comb begin
      gap_nxt      = gap_cnt;
      ref_lost_nxt = ref_lost;
      if (ref_edge) begin
         gap_nxt      = '0;
         ref_lost_nxt = 1'b0;
      end else begin
         if (gap_cnt != GAP_W'(REF_TIMEOUT)) begin
            gap_nxt = gap_cnt + GAP_W'(1);
         end
         ref_lost_nxt = (gap_nxt == GAP_W'(REF_TIMEOUT));
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_sync  <= '0;
         acc       <= '0;
         nco_out   <= 1'b0;
         phase_err <= '0;
         integ     <= '0;
         fcw_out   <= '0;
         lock_cnt  <= '0;
         lock      <= 1'b0;
         gap_cnt   <= '0;
         ref_lost  <= 1'b0;
      end else if (ena) begin
         ref_sync <= {ref_sync[1:0], ref_in};
         acc      <= acc + ACC_W'(fcw_out);
         nco_out  <= acc[ACC_W-1];
         if (ref_edge) begin
            phase_err <= err;
         end
         integ    <= integ_nxt;
         fcw_out  <= fcw_nxt;
         lock_cnt <= lock_cnt_nxt;
         lock     <= lock_nxt;
         gap_cnt  <= gap_nxt;
         ref_lost <= ref_lost_nxt;
      end
   end

endmodule

// File: tb/tb_dpll_nco_core.sv
// Directed testbench for dpll_nco_core with a scoreboard queue of expectations.
module tb_dpll_nco_core;

   localparam int unsigned FCW_W = 12;
   localparam int unsigned ERR_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             ena;
   logic             ref_in;
   logic [1:0]       mode;
   logic [FCW_W-1:0] fcw_nom;
   logic             nco_out;
   logic [FCW_W-1:0] fcw_out;
   logic [ERR_W-1:0] phase_err;
   logic             lock;
   logic             ref_lost;

   always #5 clk = ~clk;

   dpll_nco_core dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .ref_in    (ref_in),
      .mode      (mode),
      .fcw_nom   (fcw_nom),
      .nco_out   (nco_out),
      .fcw_out   (fcw_out),
      .phase_err (phase_err),
      .lock      (lock),
      .ref_lost  (ref_lost)
   );

   typedef struct {
      string                tag;
      logic signed [31:0]   exp;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0;
   int   n_bad   = 0;

   task automatic push(input string tag, input logic signed [31:0] v);
      exp_t e;
      e.tag = tag;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic pop_check(input logic signed [31:0] obs);
      exp_t e;
      n_total++;
      if (sb.size() == 0) begin
         n_bad++;
         $error("FAIL scoreboard_empty: observed=%0d expected=<entry>", obs);
         return;
      end
      e = sb.pop_front();
      assert (obs === e.exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
   endtask

   // Called at a negedge; returns at the negedge where nco_out is first seen rising
   task automatic wait_nco_rise();
      logic prev;
      bit   found;
      found = 1'b0;
      prev  = nco_out;
      for (int i = 0; i < 600 && !found; i++) begin
         @(negedge clk);
         if (!prev && nco_out) found = 1'b1;
         prev = nco_out;
      end
      if (!found) begin
         n_total++;
         n_bad++;
         $error("FAIL nco_rise_timeout: observed=none expected=rise");
      end
   endtask

   // One reference period starting at the current negedge; the edge's effects
   // are visible 3 negedges later, and the post-edge FCW one negedge after that.
   task automatic ref_pulse(input string name, input int period, input bit chk_pe,
                            input int pe, input bit lk, input int f3, input int f4,
                            input bit lost);
      ref_in = 1'b1;
      if (chk_pe) push({name, "_phase_err"}, pe);
      push({name, "_lock"}, 32'(lk));
      push({name, "_ref_lost"}, 32'(lost));
      push({name, "_fcw_edge"}, f3);
      push({name, "_fcw_after"}, f4);
      for (int i = 1; i <= period; i++) begin
         @(negedge clk);
         if (i == period / 2) ref_in = 1'b0;
         if (i == 3) begin
            if (chk_pe) pop_check($signed(phase_err));
            pop_check(32'(lock));
            pop_check(32'(ref_lost));
            pop_check(32'(fcw_out));
         end
         if (i == 4) pop_check(32'(fcw_out));
      end
   endtask

   initial begin
      logic samp[700];
      int   r1, r2, highs, toggles;
      logic prev_nco;

      rst     = 1'b1;
      ena     = 1'b1;
      ref_in  = 1'b0;
      mode    = 2'b00;
      fcw_nom = 12'h123;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      push("open_loop_fcw", 32'h123);
      pop_check(32'(fcw_out));

      // Asynchronous reset between clock edges
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      push("rst_nco_out", 0);   pop_check(32'(nco_out));
      push("rst_fcw_out", 0);   pop_check(32'(fcw_out));
      push("rst_phase_err", 0); pop_check($signed(phase_err));
      push("rst_lock", 0);      pop_check(32'(lock));
      push("rst_ref_lost", 0);  pop_check(32'(ref_lost));
      repeat (2) @(negedge clk);
      rst     = 1'b0;
      fcw_nom = 12'h100;
      push("fcw_at_release", 0);
      pop_check(32'(fcw_out));
      @(negedge clk);
      push("fcw_one_cycle", 32'h100);
      pop_check(32'(fcw_out));

      // NCO period and duty at fcw 0x100
      for (int i = 0; i < 700; i++) begin
         samp[i] = nco_out;
         @(negedge clk);
      end
      r1 = -1;
      r2 = -1;
      for (int i = 1; i < 700; i++) begin
         if (!samp[i-1] && samp[i]) begin
            if (r1 < 0) r1 = i;
            else if (r2 < 0) r2 = i;
         end
      end
      highs = 0;
      if (r1 >= 0 && r1 + 256 <= 700)
         for (int i = r1; i < r1 + 256; i++) highs += int'(samp[i]);
      push("nco_period", 256);
      pop_check(r2 - r1);
      push("nco_high_cycles", 128);
      pop_check(highs);

      // Open-loop clamp limits
      fcw_nom = 12'h000;
      @(negedge clk);
      push("clamp_low", 1);
      pop_check(32'(fcw_out));
      fcw_nom = 12'hFFF;
      @(negedge clk);
      push("clamp_high", 32'hFFF);
      pop_check(32'(fcw_out));

      // Closed loop, frequency-matched reference aligned to e = +2
      fcw_nom = 12'h100;
      mode    = 2'b01;
      repeat (4) @(negedge clk);
      push("pi_idle_fcw", 32'h100);
      pop_check(32'(fcw_out));
      wait_nco_rise();
      repeat (127) @(negedge clk);
      for (int p = 1; p <= 20; p++)
         ref_pulse("lock_acq", 256, 1'b1, 2, (p >= 16), 32'h100, 32'h100, 1'b0);
      ref_pulse("lock_hold", 240, 1'b1, 2, 1'b1, 32'h100, 32'h100, 1'b0);

      // Early edge: e = -14, P = -4, I = -1
      ref_pulse("step", 8, 1'b1, -14, 1'b0, 32'h105, 32'h101, 1'b0);

      // Reference loss with a 50-cycle enable freeze inside the gap
      toggles = 0;
      prev_nco = nco_out;
      for (int c = 1; c <= 4141; c++) begin
         @(negedge clk);
         if (c > 1000 && c <= 1050) begin
            if (nco_out !== prev_nco) toggles++;
         end
         prev_nco = nco_out;
         if (c == 1000) ena = 1'b0;
         if (c == 1025) begin
            push("freeze_fcw", 32'h101);   pop_check(32'(fcw_out));
            push("freeze_ref_lost", 0);    pop_check(32'(ref_lost));
         end
         if (c == 1050) begin
            ena = 1'b1;
            push("freeze_nco_toggles", 0);
            pop_check(toggles);
         end
         if (c == 4140) begin
            push("loss_before_timeout", 0);
            pop_check(32'(ref_lost));
         end
      end
      push("loss_ref_lost", 1);  pop_check(32'(ref_lost));
      push("loss_fcw", 32'h101); pop_check(32'(fcw_out));
      push("loss_lock", 0);      pop_check(32'(lock));

      // Clear integrator, then return to PI while the reference is still lost
      mode = 2'b00;
      repeat (4) @(negedge clk);
      push("open_clear_fcw", 32'h100); pop_check(32'(fcw_out));
      push("open_ref_lost", 1);        pop_check(32'(ref_lost));
      mode = 2'b01;
      repeat (4) @(negedge clk);
      push("lost_pi_fcw", 32'h100);    pop_check(32'(fcw_out));
      wait_nco_rise();
      repeat (165) @(negedge clk);
      ref_pulse("resume1", 256, 1'b1, 40, 1'b0, 32'h100, 32'h100, 1'b0);
      ref_pulse("resume2", 256, 1'b1, 40, 1'b0, 32'h0F5, 32'h0FF, 1'b0);

      // Hold: integrator frozen, FCW constant despite phase drift
      mode = 2'b10;
      for (int p = 0; p < 3; p++)
         ref_pulse("hold", 250, 1'b0, 0, 1'b0, 32'h0FF, 32'h0FF, 1'b0);

      // PI clamp: fcw_nom = 1 with a large positive error
      mode = 2'b00;
      repeat (4) @(negedge clk);
      push("pre_clamp_fcw", 32'h100);
      pop_check(32'(fcw_out));
      mode = 2'b01;
      repeat (4) @(negedge clk);
      wait_nco_rise();
      repeat (225) @(negedge clk);
      fcw_nom = 12'h001;
      ref_pulse("pi_clamp", 256, 1'b0, 0, 1'b0, 1, 1, 1'b0);
      repeat (20) @(negedge clk);
      push("pi_clamp_later", 1);
      pop_check(32'(fcw_out));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/dpll_nco_core.md
Name: dpll_nco_core

Overview:
Parametrised all-digital PLL core: phase-accumulator NCO steered by a sampled phase detector and a PI loop filter, with lock detection and reference-loss holdover. Next generation of our fixed-width DPLL. Width, gains and lock criteria are generic, and open-loop/closed-loop/hold modes are selectable. Instantiated inside the top-level tile wrapper; ref_in driven from a dedicated input pin.

Parameters:
ACC_W, 16, phase accumulator width (bits)
FCW_W, 12, frequency control word width; FCW_W <= ACC_W
ERR_W, 8, phase error width: top ERR_W accumulator bits, two's complement
KP_SHIFT, 2, proportional gain = 2^-KP_SHIFT
KI_SHIFT, 5, integral gain = 2^-KI_SHIFT
LOCK_TOL, 4, max |phase_err| counted as in-lock
LOCK_CNT, 16, consecutive in-tolerance ref edges needed to assert lock
REF_TIMEOUT, 4096, clk cycles without a ref edge before ref_lost

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
ena  in  1  clock enable; low freezes all state
ref_in  in  1  asynchronous reference clock
mode  in  2  00 open-loop, 01 closed-loop PI, 10 hold, 11 treated as 00
fcw_nom  in  FCW_W  nominal frequency control word
nco_out  out  1  registered accumulator MSB
fcw_out  out  FCW_W  effective FCW currently applied
phase_err  out  ERR_W  signed error sampled at last ref edge
lock  out  1  lock indicator
ref_lost  out  1  reference timeout flag

Behaviour:
- Reset (async assert, sync release): acc=0, integrator=0, fcw_out=0, nco_out=0, phase_err=0, lock=0, ref_lost=0, sync flops=0, counters=0. Outputs go to 0 immediately, without a clock edge.
- ena=0: every register holds. ena=1: normal update each clk.
- ref_in passes through a 2-flop synchroniser and a rising-edge detector. ref_edge is a 1-cycle pulse, 3 clk after the ref_in rise, +0/+1 cycle of sync uncertainty.
- NCO: acc <= acc + zero_ext(fcw_out), modulo 2^ACC_W (wraps silently). nco_out <= acc[ACC_W-1].
- Phase detector, on ref_edge:
  - e = acc[ACC_W-1 -: ERR_W] as signed; phase_err <= e.
  - Target is ref edge coinciding with acc wrap (e=0). e>0 means the NCO is early/fast.
- Integrator: signed, FCW_W+2 bits, saturating at +/-(2^(FCW_W+1)-1).
- fcw_out <= clamp(fcw_nom - corr, 1, 2^FCW_W-1) every enabled cycle. Subtraction uses signed FCW_W+3-bit arithmetic. corr depends on mode:
  - Open-loop (00/11): corr=0; integrator cleared to 0.
  - PI (01), on ref_edge: I <= sat(I + (e>>>KI_SHIFT)). The update cycle uses corr = (e>>>KP_SHIFT) + new I. Between edges, corr = I only; the proportional term applies for exactly one cycle.
  - Hold (10): I frozen, corr=I.
  - ref_lost=1 in PI mode: behaves as hold.
- Mode change takes effect on the next enabled edge; integrator is not reset except by entering open-loop.
- Lock detector (PI mode only):
  - On ref_edge with |e| <= LOCK_TOL, cnt increments, saturating at LOCK_CNT; lock=1 when cnt==LOCK_CNT.
  - On ref_edge with |e| > LOCK_TOL: cnt=0 and lock=0 on the same cycle.
  - mode != 01 or ref_lost=1: cnt=0, lock=0.
  - |e| for e=-2^(ERR_W-1) is computed without overflow (always out of tolerance).
- Ref timeout: gap counter counts cycles since the last ref_edge and saturates at REF_TIMEOUT.
  - ref_lost=1 on the cycle it reaches REF_TIMEOUT.
  - First subsequent ref_edge clears ref_lost and the counter. That edge's e is sampled but not integrated.
- Simultaneous ref_edge and timeout on the same cycle: the edge wins (ref_lost stays 0).

Test Plan:
- Reset: rst=1 mid-run, no clk edge -> all outputs 0 immediately. Release, mode=00, fcw_nom=0x100 (defaults) -> fcw_out=0x100 after 1 cycle; nco_out period 256 clk, 128 high.
- Clamp: mode=00, fcw_nom=0 -> fcw_out=1. In PI with large positive e and fcw_nom=0x001 -> fcw_out stays 1 and never wraps.
- Acquisition: mode=01, fcw_nom=0x100, ref period 250 clk -> fcw_out settles to 0x106 +/-1; |phase_err|<=4; lock=1 within 200 ref edges and stays 1 for 100 further edges.
- Step disturbance: after lock, ref period jumps to 240 -> lock drops on the first out-of-tolerance edge and cnt restarts. Relock with fcw_out ~0x111 +/-1.
- Ref loss: after lock, stop ref_in -> exactly 4096 clk after last ref_edge, ref_lost=1, lock=0, fcw_out frozen at pre-loss value. Resume ref -> ref_lost=0 at the first edge, integration resumes at the second.
- Hold/enable: lock, then mode=10 -> fcw_out constant while phase drifts. ena=0 for 50 cycles -> acc, nco_out, fcw_out, counters all unchanged.
